// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter for the shared data memory.
// It supports a burst lock with a starvation limit and returns registered read data.
module dmem_arbiter #(
  parameter int DBITS    = 32,
  parameter int ABITS    = 32,
  parameter int LOCK_MAX = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic             we0,
  input  logic             we1,
  input  logic             lock0,
  input  logic             lock1,
  input  logic [ABITS-1:0] addr0,
  input  logic [ABITS-1:0] addr1,
  input  logic [DBITS-1:0] wdata0,
  input  logic [DBITS-1:0] wdata1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             rvalid0,
  output logic             rvalid1,
  output logic [DBITS-1:0] rdata0,
  output logic [DBITS-1:0] rdata1,
  output logic             mem_en,
  output logic             mem_we,
  output logic [ABITS-1:0] mem_addr,
  output logic [DBITS-1:0] mem_din,
  input  logic [DBITS-1:0] mem_dout
);

  localparam logic [7:0] LOCK_LIM = 8'(LOCK_MAX);

  logic       rr_ptr_r;
  logic       owner_vld_r;
  logic       owner_r;
  logic [7:0] lock_cnt_r;

  logic       rr_ptr_s;
  logic       owner_vld_s;
  logic       owner_s;
  logic [7:0] lock_cnt_s;

  logic       gnt0_s;
  logic       gnt1_s;
  logic       forced_s;
  logic       lock_act_s;
  logic       win_s;
  logic       win_lock_s;
  logic       other_req_s;

  logic             rvalid0_r;
  logic             rvalid1_r;
  logic [DBITS-1:0] rdata0_r;
  logic [DBITS-1:0] rdata1_r;

  // Arbitration: single requester wins outright, contention goes to lock owner or rr_ptr
  always_comb begin
    gnt0_s     = 1'b0;
    gnt1_s     = 1'b0;
    forced_s   = 1'b0;
    lock_act_s = owner_vld_r & (owner_r ? req1 : req0);
    case ({req1, req0})
      2'b01: gnt0_s = 1'b1;
      2'b10: gnt1_s = 1'b1;
      2'b11: begin
        if (lock_act_s) begin
          if (lock_cnt_r < LOCK_LIM) begin
            gnt0_s = ~owner_r;
            gnt1_s = owner_r;
          end else begin
            // Waiter has been starved long enough: hand the cycle over.
            gnt0_s   = owner_r;
            gnt1_s   = ~owner_r;
            forced_s = 1'b1;
          end
        end else begin
          gnt0_s = ~rr_ptr_r;
          gnt1_s = rr_ptr_r;
        end
      end
      default: begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
      end
    endcase
  end

  assign gnt0 = gnt0_s & rst_n;
  assign gnt1 = gnt1_s & rst_n;

  // Memory drive mux, zeroed when no one is granted
  always_comb begin
    mem_en = gnt0 | gnt1;
    if (gnt0) begin
      mem_we   = we0;
      mem_addr = addr0;
      mem_din  = wdata0;
    end else if (gnt1) begin
      mem_we   = we1;
      mem_addr = addr1;
      mem_din  = wdata1;
    end else begin
      mem_we   = 1'b0;
      mem_addr = {ABITS{1'b0}};
      mem_din  = {DBITS{1'b0}};
    end
  end

  // Next-state for round-robin pointer, lock owner and contended-cycle counter
  always_comb begin
    rr_ptr_s    = rr_ptr_r;
    owner_vld_s = 1'b0;
    owner_s     = owner_r;
    lock_cnt_s  = 8'd0;
    win_s       = gnt1_s;
    win_lock_s  = gnt1_s ? lock1 : lock0;
    other_req_s = gnt1_s ? req0 : req1;
    if (gnt0_s | gnt1_s) begin
      rr_ptr_s = ~win_s;
      if (forced_s) begin
        owner_vld_s = 1'b0;
        lock_cnt_s  = 8'd0;
      end else if (win_lock_s) begin
        owner_vld_s = 1'b1;
        owner_s     = win_s;
        if (owner_vld_r && (owner_r == win_s) && other_req_s) begin
          lock_cnt_s = (lock_cnt_r < LOCK_LIM) ? lock_cnt_r + 8'd1 : LOCK_LIM;
        end else begin
          lock_cnt_s = 8'd0;
        end
      end else begin
        owner_vld_s = 1'b0;
        lock_cnt_s  = 8'd0;
      end
    end else begin
      owner_vld_s = 1'b0;
      lock_cnt_s  = 8'd0;
    end
  end

  // Arbitration state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_r    <= 1'b0;
      owner_vld_r <= 1'b0;
      owner_r     <= 1'b0;
      lock_cnt_r  <= 8'd0;
    end else begin
      rr_ptr_r    <= rr_ptr_s;
      owner_vld_r <= owner_vld_s;
      owner_r     <= owner_s;
      lock_cnt_r  <= lock_cnt_s;
    end
  end

  // Read return: capture memory data for the granted reader, pulse its rvalid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid0_r <= 1'b0;
      rvalid1_r <= 1'b0;
      rdata0_r  <= {DBITS{1'b0}};
      rdata1_r  <= {DBITS{1'b0}};
    end else begin
      rvalid0_r <= gnt0_s & ~we0;
      rvalid1_r <= gnt1_s & ~we1;
      if (gnt0_s & ~we0) begin
        rdata0_r <= mem_dout;
      end
      if (gnt1_s & ~we1) begin
        rdata1_r <= mem_dout;
      end
    end
  end

  assign rvalid0 = rvalid0_r;
  assign rvalid1 = rvalid1_r;
  assign rdata0  = rdata0_r;
  assign rdata1  = rdata1_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter against a behavioural model of the sharing rules.
// It also runs directed scenarios with hand-computed expectations.
module tb_dmem_arbiter;

  localparam int LOCK_MAX = 8;

  logic        clk;
  logic        rst_n;
  logic        req0, req1, we0, we1, lock0, lock1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [31:0] rdata0, rdata1;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_din, mem_dout;

  int checks   = 0;
  int failures = 0;

  dmem_arbiter #(.DBITS(32), .ABITS(32), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1), .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
  endfunction

  // Bench-side memory: synchronous write, combinational read
  logic [31:0] tb_mem [16];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) tb_mem[i] <= init_word(i);
    end else if (mem_en && mem_we) begin
      tb_mem[mem_addr[3:0]] <= mem_din;
    end
  end
  assign mem_dout = tb_mem[mem_addr[3:0]];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model state
  int          m_pref, m_own, m_cnt, w;
  bit          forced, wlock, oreq;
  logic        m_rv0, m_rv1;
  logic [31:0] m_rd0, m_rd1;
  logic [31:0] ref_mem [16];
  logic [31:0] e_addr, e_din;
  logic        e_we;

  // Compare process: checks every cycle, then advances the model past the next edge
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_gnt0", gnt0, 1'b0);
      chk("rst_gnt1", gnt1, 1'b0);
      chk("rst_mem_en", mem_en, 1'b0);
      chk("rst_rvalid0", rvalid0, 1'b0);
      chk("rst_rvalid1", rvalid1, 1'b0);
      chk("rst_rdata0", rdata0, 32'd0);
      chk("rst_rdata1", rdata1, 32'd0);
      m_pref = 0; m_own = -1; m_cnt = 0;
      m_rv0 = 1'b0; m_rv1 = 1'b0; m_rd0 = 32'd0; m_rd1 = 32'd0;
      for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    end else begin
      forced = 1'b0;
      if (!req0 && !req1) w = -1;
      else if (!req1) w = 0;
      else if (!req0) w = 1;
      else if (m_own >= 0 && ((m_own == 0) ? req0 : req1)) begin
        if (m_cnt < LOCK_MAX) w = m_own;
        else begin w = 1 - m_own; forced = 1'b1; end
      end else w = m_pref;
      e_we   = (w == 0) ? we0 : (w == 1) ? we1 : 1'b0;
      e_addr = (w == 0) ? addr0 : (w == 1) ? addr1 : 32'd0;
      e_din  = (w == 0) ? wdata0 : (w == 1) ? wdata1 : 32'd0;
      chk("gnt0", gnt0, w == 0);
      chk("gnt1", gnt1, w == 1);
      chk("mem_en", mem_en, w >= 0);
      chk("mem_we", mem_we, e_we);
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_din", mem_din, e_din);
      chk("rvalid0", rvalid0, m_rv0);
      chk("rvalid1", rvalid1, m_rv1);
      chk("rdata0", rdata0, m_rd0);
      chk("rdata1", rdata1, m_rd1);
      m_rv0 = (w == 0) && !we0;
      m_rv1 = (w == 1) && !we1;
      if (m_rv0) m_rd0 = ref_mem[addr0[3:0]];
      if (m_rv1) m_rd1 = ref_mem[addr1[3:0]];
      if (w >= 0 && e_we) ref_mem[e_addr[3:0]] = e_din;
      if (w < 0 || forced) begin
        m_own = -1; m_cnt = 0;
      end else begin
        m_pref = 1 - w;
        wlock  = (w == 0) ? lock0 : lock1;
        oreq   = (w == 0) ? req1 : req0;
        if (wlock) begin
          m_cnt = (m_own == w && oreq) ? ((m_cnt < LOCK_MAX) ? m_cnt + 1 : LOCK_MAX) : 0;
          m_own = w;
        end else begin
          m_own = -1; m_cnt = 0;
        end
      end
      if (forced) m_pref = 1 - w;
    end
  end

  task automatic set0(input logic r, input logic wr, input logic l, input logic [31:0] a, input logic [31:0] d);
    req0 = r; we0 = wr; lock0 = l; addr0 = a; wdata0 = d;
  endtask

  task automatic set1(input logic r, input logic wr, input logic l, input logic [31:0] a, input logic [31:0] d);
    req1 = r; we1 = wr; lock1 = l; addr1 = a; wdata1 = d;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic g0, g1, p0, p1;

  initial begin
    rst_n = 1'b1;
    set0(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    set1(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("lit_reset_rvalid1", rvalid1, 1'b0);
    chk("lit_reset_rdata0", rdata0, 32'd0);
    chk("lit_reset_mem_en", mem_en, 1'b0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // Write DEADBEEF to addr 5 via port 0, read it back via port 1
    set0(1'b1, 1'b1, 1'b0, 32'd5, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("lit_wr_gnt0", gnt0, 1'b1);
    chk("lit_wr_mem_we", mem_we, 1'b1);
    next_cycle();
    set0(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    set1(1'b1, 1'b0, 1'b0, 32'd5, 32'd0);
    @(negedge clk);
    chk("lit_rd_gnt1", gnt1, 1'b1);
    chk("lit_rd_mem_addr", mem_addr, 32'd5);
    chk("lit_wr_no_rvalid0", rvalid0, 1'b0);
    next_cycle();
    set1(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    chk("lit_rd_rvalid1", rvalid1, 1'b1);
    chk("lit_rd_rdata1", rdata1, 32'hDEAD_BEEF);
    chk("lit_idle_mem_en", mem_en, 1'b0);
    chk("lit_idle_mem_addr", mem_addr, 32'd0);
    next_cycle();

    // Contention without lock alternates 0,1,0,1
    for (int k = 0; k < 4; k++) begin
      set0(1'b1, 1'b0, 1'b0, 32'd1, 32'd0);
      set1(1'b1, 1'b0, 1'b0, 32'd2, 32'd0);
      @(negedge clk);
      chk("lit_rr_gnt0", gnt0, (k % 2) == 0);
      next_cycle();
    end

    // Uncontended locked burst on port 1
    set0(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    for (int k = 0; k < 20; k++) begin
      set1(1'b1, 1'b0, 1'b1, 32'd3, 32'd0);
      @(negedge clk);
      chk("lit_burst_gnt1", gnt1, 1'b1);
      next_cycle();
    end

    // Starvation limit: port 0 locked, port 1 joins at cycle 2
    for (int k = 0; k < 12; k++) begin
      set0(1'b1, 1'b0, 1'b1, 32'd4, 32'd0);
      set1(k >= 2, 1'b0, 1'b0, 32'd7, 32'd0);
      @(negedge clk);
      chk("lit_starve_gnt1", gnt1, k == 10);
      next_cycle();
    end

    // Randomized traffic with sticky lock requests
    p0 = 1'b0; p1 = 1'b0; g0 = 1'b0; g1 = 1'b0;
    set0(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    set1(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    for (int k = 0; k < 3000; k++) begin
      if (!p0 || g0) begin
        p0 = ($urandom_range(0, 3) != 0);
        we0 = $urandom_range(0, 1) == 1; addr0 = $urandom; wdata0 = $urandom;
      end
      if (!p1 || g1) begin
        p1 = ($urandom_range(0, 3) != 0);
        we1 = $urandom_range(0, 1) == 1; addr1 = $urandom; wdata1 = $urandom;
      end
      if ($urandom_range(0, 15) == 0) lock0 = ~lock0;
      if ($urandom_range(0, 15) == 0) lock1 = ~lock1;
      req0 = p0; req1 = p1;
      @(negedge clk);
      g0 = gnt0; g1 = gnt1;
      next_cycle();
    end

    // Asynchronous reset while port 1 is locked with a read pending
    set0(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    set1(1'b1, 1'b0, 1'b1, 32'd9, 32'd0);
    @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("lit_arst_rvalid1", rvalid1, 1'b0);
    chk("lit_arst_rdata1", rdata1, 32'd0);
    chk("lit_arst_gnt1", gnt1, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    set0(1'b1, 1'b0, 1'b0, 32'd1, 32'd0);
    set1(1'b1, 1'b0, 1'b0, 32'd2, 32'd0);
    @(negedge clk);
    chk("lit_post_rst_gnt0", gnt0, 1'b1);
    chk("lit_post_rst_gnt1", gnt1, 1'b0);
    next_cycle();
    set0(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    next_cycle();
    set1(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
